// File: rtl/recorder_controller_pkg.sv
// Shared piano package: key ID width, recorder controller state encoding
// and a small saturating counter helper.
package recorder_controller_pkg;

    localparam int KEY_ID_BITS = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RECORD   = 3'd1,
        PLAY_REQ = 3'd2,
        PLAYING  = 3'd3,
        GAP      = 3'd4,
        DRAIN    = 3'd5
    } rc_state_e;

    // Increment a 4-bit count, holding at all-ones instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        logic [3:0] result;
        if (value == 4'hF) begin
            result = value;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a debounced button level: one registered sample,
// the edge is the current level high while last cycle's sample was low.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o
);

    logic sample_q;
    logic sample_d;

    assign sample_d = level_i;

    // Remember the previous cycle's button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign rise_o = level_i & ~sample_q;

endmodule

// File: rtl/recorder_controller.sv
// Recorder controller: turns record/play/stop buttons into recorder
// controls, sequences looped playback with a silent gap between passes,
// and selects live keyboard or playback data for the buzzer/display.
module recorder_controller #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int KEY_ID_BITS = recorder_controller_pkg::KEY_ID_BITS,
    parameter int LOOP_GAP_MS = 200,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rec_btn,
    input  logic                   play_btn,
    input  logic                   stop_btn,
    input  logic                   loop_en,
    input  logic [3:0]             loop_count,
    input  logic [KEY_ID_BITS-1:0] live_key_id,
    input  logic                   live_key_pressed,
    input  logic                   live_oct_up,
    input  logic                   live_oct_down,
    input  logic                   rec_is_recording,
    input  logic                   rec_is_playing,
    input  logic [KEY_ID_BITS-1:0] pb_key_id,
    input  logic                   pb_key_pressed,
    input  logic                   pb_oct_up,
    input  logic                   pb_oct_down,
    output logic                   rec_record_level,
    output logic                   rec_play_pulse,
    output logic [KEY_ID_BITS-1:0] out_key_id,
    output logic                   out_key_pressed,
    output logic                   out_oct_up,
    output logic                   out_oct_down,
    output logic                   src_playback,
    output logic [3:0]             loops_done,
    output logic                   busy,
    output logic                   err_empty
);
    import recorder_controller_pkg::*;

    localparam int unsigned GAP_CYCLES = LOOP_GAP_MS * (CLK_FREQ_HZ / 1000);
    localparam logic [31:0] GAP_LAST   = (GAP_CYCLES > 32'd0) ? 32'(GAP_CYCLES - 32'd1) : 32'd0;
    localparam logic [31:0] ACK_LAST   = (ACK_TIMEOUT > 32'sd0) ? 32'(ACK_TIMEOUT - 32'sd1) : 32'd0;

    logic rec_rise_s, play_rise_s, stop_rise_s;
    logic rec_full_s, src_pb_s;
    logic [3:0] loops_next_s, passes_s;

    rc_state_e   state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  loops_done_q, loops_done_d;
    logic        err_empty_q, err_empty_d;
    logic        rec_play_pulse_q, rec_play_pulse_d;
    logic        rec_record_level_q, rec_record_level_d;
    logic        busy_q, busy_d;
    logic        recording_q, recording_d;

    logic [KEY_ID_BITS-1:0] out_key_id_q, out_key_id_d;
    logic out_key_pressed_q, out_key_pressed_d;
    logic out_oct_up_q, out_oct_up_d;
    logic out_oct_down_q, out_oct_down_d;
    logic src_playback_q, src_playback_d;

    edge_detect u_rec_edge  (.clk(clk), .rst_n(rst_n), .level_i(rec_btn),  .rise_o(rec_rise_s));
    edge_detect u_play_edge (.clk(clk), .rst_n(rst_n), .level_i(play_btn), .rise_o(play_rise_s));
    edge_detect u_stop_edge (.clk(clk), .rst_n(rst_n), .level_i(stop_btn), .rise_o(stop_rise_s));

    // Recorder reports memory full by dropping its recording flag.
    assign rec_full_s   = recording_q & ~rec_is_recording;
    assign loops_next_s = sat_inc4(loops_done_q);
    assign passes_s     = (loop_count == 4'd0) ? 4'd1 : loop_count;

    // Next-state logic for the record/playback sequencer and its status flags.
    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        loops_done_d     = loops_done_q;
        err_empty_d      = err_empty_q;
        rec_play_pulse_d = 1'b0;
        recording_d      = rec_is_recording;
        case (state_q)
            IDLE: begin
                // Record wins when both buttons arrive together.
                if (rec_rise_s) begin
                    state_d = RECORD;
                end else if (play_rise_s) begin
                    state_d          = PLAY_REQ;
                    timer_d          = 32'd0;
                    loops_done_d     = 4'd0;
                    err_empty_d      = 1'b0;
                    rec_play_pulse_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RECORD: begin
                if (rec_rise_s || stop_rise_s || rec_full_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RECORD;
                end
            end
            PLAY_REQ: begin
                if (stop_rise_s) begin
                    state_d = DRAIN;
                end else if (rec_is_playing) begin
                    state_d = PLAYING;
                end else if (timer_q == ACK_LAST) begin
                    // Recorder never started: nothing stored to play.
                    state_d     = IDLE;
                    err_empty_d = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            PLAYING: begin
                if (stop_rise_s) begin
                    state_d = DRAIN;
                end else if (!rec_is_playing) begin
                    loops_done_d = loops_next_s;
                    if (loop_en && (loops_next_s < passes_s)) begin
                        state_d = GAP;
                        timer_d = 32'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = PLAYING;
                end
            end
            GAP: begin
                if (stop_rise_s) begin
                    state_d = DRAIN;
                end else if (timer_q == GAP_LAST) begin
                    state_d          = PLAY_REQ;
                    timer_d          = 32'd0;
                    rec_play_pulse_d = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            DRAIN: begin
                // The recorder cannot abort, so wait for it to finish.
                if (!rec_is_playing) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 32'd0;
            end
        endcase
        rec_record_level_d = (state_d == RECORD);
        busy_d             = (state_d != IDLE);
    end

    // Playback data is routed only while playing, not being muted by a stop
    // this cycle, and not overridden by a live key press.
    always_comb begin
        src_pb_s = (state_q == PLAYING) && !stop_rise_s && !live_key_pressed;
        if (src_pb_s) begin
            out_key_id_d      = pb_key_id;
            out_key_pressed_d = pb_key_pressed;
            out_oct_up_d      = pb_oct_up;
            out_oct_down_d    = pb_oct_down;
        end else begin
            out_key_id_d      = live_key_id;
            out_key_pressed_d = live_key_pressed;
            out_oct_up_d      = live_oct_up;
            out_oct_down_d    = live_oct_down;
        end
        src_playback_d = src_pb_s;
    end

    // Sequencer state, timer and registered control/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            timer_q            <= 32'd0;
            loops_done_q       <= 4'd0;
            err_empty_q        <= 1'b0;
            rec_play_pulse_q   <= 1'b0;
            rec_record_level_q <= 1'b0;
            busy_q             <= 1'b0;
            recording_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            timer_q            <= timer_d;
            loops_done_q       <= loops_done_d;
            err_empty_q        <= err_empty_d;
            rec_play_pulse_q   <= rec_play_pulse_d;
            rec_record_level_q <= rec_record_level_d;
            busy_q             <= busy_d;
            recording_q        <= recording_d;
        end
    end

    // Registered key/octave routing towards buzzer and display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_key_id_q      <= '0;
            out_key_pressed_q <= 1'b0;
            out_oct_up_q      <= 1'b0;
            out_oct_down_q    <= 1'b0;
            src_playback_q    <= 1'b0;
        end else begin
            out_key_id_q      <= out_key_id_d;
            out_key_pressed_q <= out_key_pressed_d;
            out_oct_up_q      <= out_oct_up_d;
            out_oct_down_q    <= out_oct_down_d;
            src_playback_q    <= src_playback_d;
        end
    end

    assign rec_record_level = rec_record_level_q;
    assign rec_play_pulse   = rec_play_pulse_q;
    assign loops_done       = loops_done_q;
    assign busy             = busy_q;
    assign err_empty        = err_empty_q;
    assign out_key_id       = out_key_id_q;
    assign out_key_pressed  = out_key_pressed_q;
    assign out_oct_up       = out_oct_up_q;
    assign out_oct_down     = out_oct_down_q;
    assign src_playback     = src_playback_q;

endmodule

// File: tb/tb_recorder_controller.sv
// Bench for recorder_controller: randomized key traffic and session shapes
// against a behavioural recorder model, pulse/gap timing derived from the
// gap length, and routing derived from "recorder playing, not stopped".
module tb_recorder_controller;

    localparam int KB      = recorder_controller_pkg::KEY_ID_BITS;
    localparam int CLK_HZ  = 10_000;
    localparam int GAP_MS  = 2;
    localparam int ACK_TO  = 8;
    localparam int GAP_LEN = GAP_MS * (CLK_HZ / 1000);

    logic clk = 1'b0;
    logic rst_n;
    logic rec_btn, play_btn, stop_btn, loop_en;
    logic [3:0] loop_count;
    logic [KB-1:0] live_key_id, pb_key_id;
    logic live_key_pressed, live_oct_up, live_oct_down;
    logic pb_key_pressed, pb_oct_up, pb_oct_down;
    logic rec_is_recording, rec_is_playing;
    logic rec_record_level, rec_play_pulse;
    logic [KB-1:0] out_key_id;
    logic out_key_pressed, out_oct_up, out_oct_down, src_playback;
    logic [3:0] loops_done;
    logic busy, err_empty;
    logic [15:0] all_outs;

    assign all_outs = {rec_record_level, rec_play_pulse, out_key_id, out_key_pressed,
                       out_oct_up, out_oct_down, src_playback, loops_done, busy, err_empty};

    recorder_controller #(
        .CLK_FREQ_HZ(CLK_HZ), .KEY_ID_BITS(KB), .LOOP_GAP_MS(GAP_MS), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rec_btn(rec_btn), .play_btn(play_btn), .stop_btn(stop_btn),
        .loop_en(loop_en), .loop_count(loop_count),
        .live_key_id(live_key_id), .live_key_pressed(live_key_pressed),
        .live_oct_up(live_oct_up), .live_oct_down(live_oct_down),
        .rec_is_recording(rec_is_recording), .rec_is_playing(rec_is_playing),
        .pb_key_id(pb_key_id), .pb_key_pressed(pb_key_pressed),
        .pb_oct_up(pb_oct_up), .pb_oct_down(pb_oct_down),
        .rec_record_level(rec_record_level), .rec_play_pulse(rec_play_pulse),
        .out_key_id(out_key_id), .out_key_pressed(out_key_pressed),
        .out_oct_up(out_oct_up), .out_oct_down(out_oct_down),
        .src_playback(src_playback), .loops_done(loops_done),
        .busy(busy), .err_empty(err_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // bench-side model state
    logic pend_rec = 1'b0, pend_play = 1'b0, pend_stop = 1'b0;
    bit   hold_keys = 1'b0;
    bit   stopped = 1'b0;
    logic play_prev = 1'b0;
    logic stop_prev = 1'b0;
    logic pulse_prev = 1'b0;
    logic [KB+3:0] exp_out = '0;
    bit   rec_model_on = 1'b0;
    int   ack_wait = -1;
    int   play_len = 10;
    int   play_rem = 0;
    int   last_fall = -1;
    int   pulse_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, predict routing, wait, check, run recorder model.
    task automatic tick();
        logic stop_edge;
        logic sel_pb;
        rec_btn   = pend_rec;
        play_btn  = pend_play;
        stop_btn  = pend_stop;
        pend_rec  = 1'b0;
        pend_play = 1'b0;
        pend_stop = 1'b0;
        if (!hold_keys) begin
            live_key_id      = KB'($urandom);
            live_key_pressed = ($urandom_range(0, 3) == 0);
            live_oct_up      = 1'($urandom);
            live_oct_down    = 1'($urandom);
            pb_key_id        = KB'($urandom);
            pb_key_pressed   = 1'($urandom);
            pb_oct_up        = 1'($urandom);
            pb_oct_down      = 1'($urandom);
        end
        if (play_btn) begin
            stopped   = 1'b0;
            last_fall = -1;
        end
        stop_edge = stop_btn & ~stop_prev;
        stop_prev = stop_btn;
        // Controller is in its playing phase one cycle after the recorder reports playing.
        sel_pb = play_prev & ~stopped & ~live_key_pressed & ~stop_edge;
        if (stop_edge) stopped = 1'b1;
        exp_out = sel_pb ? {1'b1, pb_key_pressed, pb_oct_up, pb_oct_down, pb_key_id}
                         : {1'b0, live_key_pressed, live_oct_up, live_oct_down, live_key_id};
        play_prev = rec_is_playing;

        @(negedge clk);
        cyc++;
        check_val("route", 32'({src_playback, out_key_pressed, out_oct_up, out_oct_down, out_key_id}),
                  32'(exp_out));
        if (rec_play_pulse) begin
            pulse_cnt++;
            check_val("pulse_width", 32'(pulse_prev), 32'd0);
            if (last_fall >= 0) begin
                check_val("gap_len", 32'(cyc - last_fall), 32'(GAP_LEN + 1));
                last_fall = -1;
            end
            if (rec_model_on) ack_wait = $urandom_range(0, 3);
        end
        pulse_prev = rec_play_pulse;
        // recorder: acknowledge a play request after a short delay, play for play_len cycles
        if (ack_wait >= 0) begin
            if (ack_wait == 0) begin
                rec_is_playing = 1'b1;
                play_rem       = play_len;
            end
            ack_wait--;
        end else if (rec_is_playing) begin
            play_rem--;
            if (play_rem <= 0) begin
                rec_is_playing = 1'b0;
                last_fall      = cyc;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check_val(tag, 32'(busy), 32'd0);
    endtask

    task automatic start_play(input bit le, input logic [3:0] cnt, input int len);
        loop_en      = le;
        loop_count   = cnt;
        play_len     = len;
        rec_model_on = 1'b1;
        pulse_cnt    = 0;
        pend_play    = 1'b1;
        tick();
        check_val("start_pulse", 32'(rec_play_pulse), 32'd1);
        check_val("start_err_clr", 32'(err_empty), 32'd0);
        check_val("start_loops_clr", 32'(loops_done), 32'd0);
    endtask

    task automatic run_session(input bit le, input logic [3:0] cnt, input int len);
        int passes;
        passes = le ? ((cnt == 4'd0) ? 1 : int'(cnt)) : 1;
        start_play(le, cnt, len);
        wait_idle("sess_end");
        check_val("sess_pulses", 32'(pulse_cnt), 32'(passes));
        check_val("sess_loops", 32'(loops_done), 32'(passes));
    endtask

    task automatic wait_playing(input string tag);
        int n = 0;
        while (!rec_is_playing && n < 20) begin
            tick();
            n++;
        end
        check_val(tag, 32'(rec_is_playing), 32'd1);
    endtask

    initial begin
        int n;
        int pc;
        rst_n = 1'b0;
        rec_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0;
        loop_en = 1'b0; loop_count = 4'd0;
        live_key_id = '0; live_key_pressed = 1'b0; live_oct_up = 1'b0; live_oct_down = 1'b0;
        pb_key_id = '0; pb_key_pressed = 1'b0; pb_oct_up = 1'b0; pb_oct_down = 1'b0;
        rec_is_recording = 1'b0; rec_is_playing = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_outs", 32'(all_outs), 32'd0);
        rst_n = 1'b1;

        // record: level high from the cycle after the first edge until the second edge
        pend_rec = 1'b1;
        tick();
        check_val("rec_start", 32'({rec_record_level, busy}), 32'd3);
        rec_is_recording = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) pend_play = 1'b1;
            tick();
            check_val("rec_hold", 32'({rec_record_level, busy}), 32'd3);
        end
        pend_rec = 1'b1;
        tick();
        check_val("rec_stop", 32'({rec_record_level, busy}), 32'd0);
        check_val("rec_play_ignored", 32'(pulse_cnt), 32'd0);
        rec_is_recording = 1'b0;
        tick();

        // memory full ends recording
        pend_rec = 1'b1;
        tick();
        rec_is_recording = 1'b1;
        repeat (5) tick();
        check_val("full_before", 32'(rec_record_level), 32'd1);
        rec_is_recording = 1'b0;
        tick();
        check_val("full_after", 32'({rec_record_level, busy}), 32'd0);

        // simultaneous rec+play: record wins; stop ends record; stop in idle ignored
        pend_rec = 1'b1;
        pend_play = 1'b1;
        tick();
        check_val("both_rec_wins", 32'({rec_record_level, rec_play_pulse}), 32'd2);
        pend_stop = 1'b1;
        tick();
        check_val("stop_rec", 32'(rec_record_level), 32'd0);
        tick();
        pend_stop = 1'b1;
        tick();
        check_val("stop_idle", 32'(busy), 32'd0);

        // play with no recorder response: single pulse, error after ACK_TO cycles
        rec_model_on = 1'b0;
        pulse_cnt = 0;
        pend_play = 1'b1;
        tick();
        check_val("to_pulse", 32'({rec_play_pulse, busy}), 32'd3);
        for (int i = 1; i < ACK_TO; i++) begin
            tick();
            check_val("to_wait", 32'({err_empty, busy}), 32'd1);
        end
        tick();
        check_val("to_err", 32'({err_empty, busy}), 32'd2);
        repeat (3) tick();
        check_val("to_one_pulse", 32'(pulse_cnt), 32'd1);
        check_val("to_sticky", 32'(err_empty), 32'd1);

        // three passes of 50 cycles separated by the gap
        run_session(1'b1, 4'd3, 50);

        // live key press overrides playback for one cycle
        start_play(1'b0, 4'd0, 40);
        wait_playing("ovr_ack");
        repeat (3) tick();
        hold_keys = 1'b1;
        pb_key_id = KB'(5); pb_key_pressed = 1'b1;
        live_key_id = KB'(2); live_key_pressed = 1'b1;
        tick();
        check_val("ovr_live", 32'({src_playback, out_key_id}), 32'({1'b0, KB'(2)}));
        live_key_pressed = 1'b0;
        tick();
        check_val("ovr_pb", 32'({src_playback, out_key_id}), 32'({1'b1, KB'(5)}));
        hold_keys = 1'b0;
        wait_idle("ovr_end");

        // stop mid-playing: live immediately, drain until recorder stops, no more pulses
        start_play(1'b1, 4'd3, 60);
        wait_playing("stop_ack");
        repeat (10) tick();
        pend_stop = 1'b1;
        tick();
        check_val("stop_mute", 32'({src_playback, busy}), 32'd1);
        n = 0;
        while (rec_is_playing && n < 200) begin
            tick();
            check_val("drain_busy", 32'(busy), 32'd1);
            n++;
        end
        tick();
        check_val("drain_done", 32'(busy), 32'd0);
        repeat (GAP_LEN + 10) tick();
        check_val("stop_pulses", 32'(pulse_cnt), 32'd1);

        // reset during the gap
        start_play(1'b1, 4'd2, 10);
        n = 0;
        while (last_fall < 0 && n < 200) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check_val("gap_busy", 32'(busy), 32'd1);
        pc = pulse_cnt;
        rst_n = 1'b0;
        #1;
        check_val("rst_async", 32'(all_outs), 32'd0);
        rec_is_playing = 1'b0; ack_wait = -1; play_prev = 1'b0;
        stopped = 1'b0; last_fall = -1; pulse_prev = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_hold", 32'(all_outs), 32'd0);
        check_val("rst_pulses", 32'(pulse_cnt), 32'(pc));
        rst_n = 1'b1;
        run_session(1'b0, 4'd0, 8);

        // randomized sessions
        for (int s = 0; s < 4; s++) begin
            run_session(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                        int'($urandom_range(5, 30)));
            repeat (3) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
